counter2_checker: RTL and testbench

Sequence checker for the 2-bit counter output bus. It samples the `state` bus driven by a `counter2` instance and verifies the strict 0→1→2→3→0 sequence. It locks after a run of good transitions, flags and counts sequence errors, and counts full wraps. It sits beside the counter as the observing end of the same `state` interface, for self-checking benches and on-chip health monitoring.

---
 rtl/counter2_checker_pkg.sv | 12 +
 rtl/counter2_checker_if.sv | 9 +
 rtl/counter2_checker_sat_counter.sv | 19 +
 rtl/counter2_checker.sv | 102 ++++++++++
 tb/tb_counter2_checker.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/counter2_checker_pkg.sv
// Shared definitions for the 2-bit counter bus and its sequence checker.
package counter2_checker_pkg;

  localparam int unsigned Cnt2W = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHunt = 2'd1,
    StLock = 2'd2
  } fsm_e;

endpackage

// File: rtl/counter2_checker_if.sv
// The 2-bit counter state bus: the counter drives it, observers sample it.
import counter2_checker_pkg::*;

interface counter2_checker_if;
  logic [Cnt2W-1:0] state;

  modport master (output state);
  modport slave  (input  state);
endinterface

// File: rtl/counter2_checker_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module counter2_checker_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/counter2_checker.sv
// Observes the counter state bus, locks after RELOCK good steps of 0->1->2->3->0,
// then flags and counts sequence errors and counts full wraps.
import counter2_checker_pkg::*;

module counter2_checker #(
  parameter int unsigned RELOCK = 4,
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned WRAP_W = 8
) (
  input  logic                clock,
  input  logic                clear,
  counter2_checker_if.slave   bus,
  output logic                locked,
  output logic                err_pulse,
  output logic [ERR_W-1:0]    err_count,
  output logic [WRAP_W-1:0]   wrap_count,
  output logic [Cnt2W-1:0]    expected
);

  localparam int unsigned GrW = $clog2(RELOCK + 1);

  fsm_e             fsm;
  logic [Cnt2W-1:0] last;
  logic [GrW-1:0]   good_run;
  logic [GrW-1:0]   good_run_inc;
  logic [Cnt2W-1:0] next_val;
  logic             good;
  logic             err_inc;
  logic             wrap_inc;

  always_comb begin
    next_val     = last + 2'd1;
    good         = (bus.state == next_val);
    good_run_inc = good_run + GrW'(1);
    err_inc      = (fsm == StLock) && !good;
    // A good step out of 3 in LOCK can only land on 0: that is a full wrap.
    wrap_inc     = (fsm == StLock) && good && (last == 2'd3);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      fsm       <= StIdle;
      last      <= '0;
      good_run  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      expected  <= 2'd1;
    end else begin
      last      <= bus.state;
      expected  <= bus.state + 2'd1;
      err_pulse <= 1'b0;
      unique case (fsm)
        StIdle: begin
          fsm <= StHunt;
        end
        StHunt: begin
          if (good) begin
            if (good_run_inc == GrW'(RELOCK)) begin
              fsm      <= StLock;
              locked   <= 1'b1;
              good_run <= '0;
            end else begin
              good_run <= good_run_inc;
            end
          end else begin
            good_run <= '0;
          end
        end
        StLock: begin
          if (!good) begin
            fsm       <= StHunt;
            err_pulse <= 1'b1;
            locked    <= 1'b0;
            good_run  <= '0;
          end
        end
        default: begin
          fsm <= StIdle;
        end
      endcase
    end
  end

  counter2_checker_sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clock (clock),
    .clear (clear),
    .inc   (err_inc),
    .count (err_count)
  );

  counter2_checker_sat_counter #(
    .W (WRAP_W)
  ) u_wrap_cnt (
    .clock (clock),
    .clear (clear),
    .inc   (wrap_inc),
    .count (wrap_count)
  );

endmodule

// File: tb/tb_counter2_checker.sv
// Directed bench: default checker, a 2-bit error-count variant and a RELOCK=1 variant
// all watch one shared state bus, each with its own clear.
module tb_counter2_checker;

  logic clock;
  logic clear_m, clear_e, clear_r;

  counter2_checker_if bus ();

  logic       locked_m, pulse_m;
  logic [7:0] err_m, wrap_m;
  logic [1:0] exp_m;

  logic       locked_e, pulse_e;
  logic [1:0] err_e;
  logic [7:0] wrap_e;
  logic [1:0] exp_e;

  logic       locked_r, pulse_r;
  logic [7:0] err_r, wrap_r;
  logic [1:0] exp_r;

  int n_checks;
  int n_fail;

  counter2_checker u_dut_m (
    .clock      (clock),
    .clear      (clear_m),
    .bus        (bus),
    .locked     (locked_m),
    .err_pulse  (pulse_m),
    .err_count  (err_m),
    .wrap_count (wrap_m),
    .expected   (exp_m)
  );

  counter2_checker #(
    .ERR_W (2)
  ) u_dut_e (
    .clock      (clock),
    .clear      (clear_e),
    .bus        (bus),
    .locked     (locked_e),
    .err_pulse  (pulse_e),
    .err_count  (err_e),
    .wrap_count (wrap_e),
    .expected   (exp_e)
  );

  counter2_checker #(
    .RELOCK (1)
  ) u_dut_r (
    .clock      (clock),
    .clear      (clear_r),
    .bus        (bus),
    .locked     (locked_r),
    .err_pulse  (pulse_r),
    .err_count  (err_r),
    .wrap_count (wrap_r),
    .expected   (exp_r)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge sample it, return at the next falling edge.
  task automatic drive(input logic [1:0] v);
    bus.state = v;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int         pulses;
    logic [1:0] lastv;
    int         exp_err [5];
    exp_err  = '{1, 2, 3, 3, 3};
    n_checks = 0;
    n_fail   = 0;
    clear_m  = 1'b1;
    clear_e  = 1'b1;
    clear_r  = 1'b1;
    bus.state = 2'd0;
    repeat (2) @(negedge clock);

    check("rst_locked",   32'(locked_m), 32'd0);
    check("rst_pulse",    32'(pulse_m),  32'd0);
    check("rst_err",      32'(err_m),    32'd0);
    check("rst_wrap",     32'(wrap_m),   32'd0);
    check("rst_expected", 32'(exp_m),    32'd1);

    // Ideal counter: lock on edge 5, wraps counted only once locked.
    clear_m = 1'b0;
    drive(2'd0);
    drive(2'd1);
    drive(2'd2);
    drive(2'd3);
    check("lock_e4", 32'(locked_m), 32'd0);
    drive(2'd0);
    check("lock_e5", 32'(locked_m), 32'd1);
    check("wrap_e5", 32'(wrap_m),   32'd0);
    drive(2'd1);
    check("expected_after1", 32'(exp_m), 32'd2);
    drive(2'd2);
    drive(2'd3);
    drive(2'd0);
    check("wrap_first", 32'(wrap_m), 32'd1);
    drive(2'd1);
    drive(2'd2);
    drive(2'd3);
    drive(2'd0);
    check("wrap_second", 32'(wrap_m), 32'd2);
    check("err_ideal",   32'(err_m),  32'd0);

    // Skip 1->3: error, then relock after four good edges.
    drive(2'd1);
    drive(2'd3);
    check("skip_pulse",  32'(pulse_m),  32'd1);
    check("skip_err",    32'(err_m),    32'd1);
    check("skip_locked", 32'(locked_m), 32'd0);
    drive(2'd0);
    check("skip_pulse_drop", 32'(pulse_m), 32'd0);
    drive(2'd1);
    drive(2'd2);
    check("relock_3good", 32'(locked_m), 32'd0);
    drive(2'd3);
    check("relock_4good", 32'(locked_m), 32'd1);
    check("wrap_hunt",    32'(wrap_m),   32'd2);

    // Stuck input after lock: exactly one error.
    drive(2'd0);
    check("wrap_third", 32'(wrap_m), 32'd3);
    drive(2'd1);
    drive(2'd2);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive(2'd2);
      if (pulse_m) pulses++;
      check("stuck_locked", 32'(locked_m), 32'd0);
    end
    check("stuck_pulses", 32'(pulses), 32'd1);
    check("stuck_err",    32'(err_m),  32'd2);

    // Relock, reach wrap_count 5, then clear mid-cycle.
    drive(2'd3);
    drive(2'd0);
    drive(2'd1);
    drive(2'd2);
    check("relock_stuck", 32'(locked_m), 32'd1);
    drive(2'd3);
    drive(2'd0);
    drive(2'd1);
    drive(2'd2);
    drive(2'd3);
    drive(2'd0);
    check("wrap_five",   32'(wrap_m),   32'd5);
    check("locked_five", 32'(locked_m), 32'd1);
    #3 clear_m = 1'b1;
    #1;
    check("aclr_locked",   32'(locked_m), 32'd0);
    check("aclr_wrap",     32'(wrap_m),   32'd0);
    check("aclr_err",      32'(err_m),    32'd0);
    check("aclr_pulse",    32'(pulse_m),  32'd0);
    check("aclr_expected", 32'(exp_m),    32'd1);

    // ERR_W=2: count saturates at 3 while pulses keep firing.
    @(negedge clock);
    clear_e = 1'b0;
    lastv   = 2'd0;
    drive(lastv);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) begin
        lastv = lastv + 2'd1;
        drive(lastv);
      end
      check("sat_locked", 32'(locked_e), 32'd1);
      lastv = lastv + 2'd2;
      drive(lastv);
      check("sat_pulse", 32'(pulse_e), 32'd1);
      check("sat_err",   32'(err_e),   32'(exp_err[i]));
    end

    // RELOCK=1: lock on edge 2, a repeated value breaks it.
    clear_r = 1'b0;
    drive(2'd0);
    check("r1_e1_locked", 32'(locked_r), 32'd0);
    drive(2'd1);
    check("r1_e2_locked", 32'(locked_r), 32'd1);
    drive(2'd1);
    check("r1_err_pulse",  32'(pulse_r),  32'd1);
    check("r1_err_locked", 32'(locked_r), 32'd0);
    check("r1_err_count",  32'(err_r),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
